// File: rtl/seg_rom_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seg_rom_scheduler
// Brief    : Sweeps snapshotted digit nibbles through one shared registered
//            7-segment ROM and latches each pattern into a per-digit register.
// Revision : 1.0 - initial release
// ============================================================================
module seg_rom_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [4*NUM_DIGITS-1:0]          digits_in,
    input  logic [NUM_DIGITS-1:0]            blank_in,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    input  logic                             force_update,
    output logic [3:0]                       rom_addr,
    input  logic [DATA_WIDTH-1:0]            rom_data,
    output logic [DATA_WIDTH*NUM_DIGITS-1:0] hex_out,
    output logic                             busy,
    output logic                             update_done
);

    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_LOAD = 3'd1;
    localparam logic [2:0] c_S_WAIT = 3'd2;
    localparam logic [2:0] c_S_CAPT = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    logic [2:0]                  r_state;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_IDX_W-1:0]          r_idx;
    logic                        r_pending;
    logic                        r_busy;
    logic                        r_done;
    logic [3:0]                  r_rom_addr;
    logic [4*NUM_DIGITS-1:0]     r_snap_digits;
    logic [NUM_DIGITS-1:0]       r_snap_blank;
    logic [NUM_DIGITS-1:0]       r_snap_dp;
    logic [DATA_WIDTH-1:0]       r_hex [NUM_DIGITS];

    logic                        w_tick;
    logic                        w_start;
    logic [3:0]                  w_nibble;
    logic                        w_blank;
    logic                        w_dp;
    logic [DATA_WIDTH-1:0]       w_pattern;
    logic                        w_rom_dp_unused;

    assign w_tick          = (r_cnt == c_CNT_MAX);
    assign w_start         = (r_state == c_S_IDLE) && (w_tick || force_update || r_pending);
    // The ROM's own DP bit is ignored; the DP comes from the snapshot instead.
    assign w_rom_dp_unused = rom_data[DATA_WIDTH-1];
    assign w_pattern       = w_blank ? {DATA_WIDTH{1'b1}}
                                     : {~w_dp, rom_data[DATA_WIDTH-2:0]};

    always_comb begin
        w_nibble = 4'h0;
        w_blank  = 1'b0;
        w_dp     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nibble = r_snap_digits[4*i +: 4];
                w_blank  = r_snap_blank[i];
                w_dp     = r_snap_dp[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_S_IDLE;
            r_idx         <= '0;
            r_pending     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rom_addr    <= 4'h0;
            r_snap_digits <= '0;
            r_snap_blank  <= '0;
            r_snap_dp     <= '0;
        end else begin
            r_done <= 1'b0;
            // Requests arriving outside IDLE collapse into one deferred sweep.
            if ((r_state != c_S_IDLE) && (w_tick || force_update)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_start) begin
                        r_snap_digits <= digits_in;
                        r_snap_blank  <= blank_in;
                        r_snap_dp     <= dp_in;
                        r_pending     <= 1'b0;
                        r_idx         <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= c_S_LOAD;
                    end
                end
                c_S_LOAD: begin
                    r_rom_addr <= w_nibble;
                    r_state    <= c_S_WAIT;
                end
                c_S_WAIT: begin
                    r_state <= c_S_CAPT;
                end
                c_S_CAPT: begin
                    if (r_idx == c_IDX_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_S_DONE;
                    end else begin
                        r_idx   <= r_idx + c_IDX_W'(1);
                        r_state <= c_S_LOAD;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[i] <= {DATA_WIDTH{1'b1}};
            end
        end else if (r_state == c_S_CAPT) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_idx == c_IDX_W'(i)) begin
                    r_hex[i] <= w_pattern;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hex_pack
        assign hex_out[DATA_WIDTH*gi +: DATA_WIDTH] = r_hex[gi];
    end

    assign rom_addr    = r_rom_addr;
    assign busy        = r_busy;
    assign update_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_rom_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_rom_scheduler
// Brief    : Scoreboard bench for seg_rom_scheduler with a registered ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_rom_scheduler;

    logic        clk;
    logic        rst_a_n, rst_b_n;
    logic [23:0] digits_a, digits_b;
    logic [5:0]  blank_a, dp_a;
    logic        force_a;
    logic [3:0]  rom_addr_a, rom_addr_b;
    logic [7:0]  rom_data_a, rom_data_b;
    logic [47:0] hex_a, hex_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        b_finished;

    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] exp_q [$];

    seg_rom_scheduler #(.DATA_WIDTH(8), .NUM_DIGITS(6), .REFRESH_DIV(50000)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .digits_in(digits_a), .blank_in(blank_a),
        .dp_in(dp_a), .force_update(force_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .hex_out(hex_a), .busy(busy_a), .update_done(done_a)
    );

    seg_rom_scheduler #(.DATA_WIDTH(8), .NUM_DIGITS(6), .REFRESH_DIV(32)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .digits_in(digits_b), .blank_in(6'b0),
        .dp_in(6'b0), .force_update(1'b0), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .hex_out(hex_b), .busy(busy_b), .update_done(done_b)
    );

    function automatic logic [7:0] seg_rom(input logic [3:0] a);
        case (a)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  4'hF: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [47:0] model_hex(input logic [23:0] d, input logic [5:0] bl,
                                              input logic [5:0] dpv);
        logic [47:0] r;
        logic [7:0]  s;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            s = seg_rom(d[4*i +: 4]);
            r[8*i +: 8] = bl[i] ? 8'hFF : {~dpv[i], s[6:0]};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rom_data_a <= seg_rom(rom_addr_a);
        rom_data_b <= seg_rom(rom_addr_b);
    end

    // Scoreboard: every update_done pulse on dut_a consumes one expected frame.
    always @(negedge clk) begin
        logic [47:0] e;
        if (rst_a_n && done_a) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 48'(done_a), 48'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_hex", hex_a, e);
            end
        end
    end

    task automatic sweep(input logic [47:0] exp, input int chg_at, input logic [23:0] chg_val,
                         output int lat, output int bcnt);
        exp_q.push_back(exp);
        force_a = 1'b1;
        @(negedge clk);
        force_a = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done_a && lat < 40) begin
            if (busy_a) bcnt++;
            if (lat == chg_at) digits_a = chg_val;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin : main_proc
        int lat, bcnt, nd, d1, d2, extra;
        rst_a_n  = 1'b0;
        force_a  = 1'b0;
        digits_a = 24'h0;
        blank_a  = 6'h0;
        dp_a     = 6'h0;
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("init_hex", hex_a, 48'hFFFF_FFFF_FFFF);
        chk("init_busy", 48'(busy_a), 48'(0));
        chk("init_done", 48'(done_a), 48'(0));
        chk("init_addr", 48'(rom_addr_a), 48'(0));

        digits_a = 24'h543210;
        sweep(48'h92_99_B0_A4_F9_C0, -1, 24'h0, lat, bcnt);
        chk("basic_latency", 48'(lat), 48'(19));
        chk("basic_busy_cycles", 48'(bcnt), 48'(18));
        chk("basic_busy_in_done", 48'(busy_a), 48'(0));
        @(negedge clk);
        chk("basic_done_one_cycle", 48'(done_a), 48'(0));

        digits_a = 24'hF0A888;
        blank_a  = 6'b010000;
        dp_a     = 6'b000101;
        sweep(48'h8E_FF_88_00_80_00, -1, 24'h0, lat, bcnt);
        chk("bdp_latency", 48'(lat), 48'(19));
        @(negedge clk);

        blank_a  = 6'h0;
        dp_a     = 6'h0;
        digits_a = 24'h000000;
        sweep(model_hex(24'h000000, 6'h0, 6'h0), 2, 24'h111111, lat, bcnt);
        chk("snap_latency", 48'(lat), 48'(19));
        @(negedge clk);
        sweep(model_hex(24'h111111, 6'h0, 6'h0), -1, 24'h0, lat, bcnt);
        chk("snap2_latency", 48'(lat), 48'(19));
        @(negedge clk);

        digits_a = 24'h3A5C7E;
        exp_q.push_back(model_hex(24'h3A5C7E, 6'h0, 6'h0));
        exp_q.push_back(model_hex(24'h3A5C7E, 6'h0, 6'h0));
        force_a = 1'b1;
        @(negedge clk);
        nd = 0; d1 = -1; d2 = -1; extra = 0;
        for (int l = 1; l <= 70; l++) begin
            force_a = (l == 5 || l == 10);
            if (done_a) begin
                nd++;
                if (d1 < 0) d1 = l;
                else if (d2 < 0) d2 = l;
            end
            @(negedge clk);
        end
        force_a = 1'b0;
        chk("pend_done_count", 48'(nd), 48'(2));
        chk("pend_first_done", 48'(d1), 48'(19));
        chk("pend_gap", 48'(d2 - d1), 48'(20));

        digits_a = 24'h777777;
        force_a  = 1'b1;
        @(negedge clk);
        force_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_pre_busy", 48'(busy_a), 48'(1));
        #2 rst_a_n = 1'b0;
        #1;
        chk("rst_hex", hex_a, 48'hFFFF_FFFF_FFFF);
        chk("rst_busy", 48'(busy_a), 48'(0));
        chk("rst_done", 48'(done_a), 48'(0));
        chk("rst_addr", 48'(rom_addr_a), 48'(0));
        @(negedge clk);
        rst_a_n = 1'b1;
        for (int l = 0; l < 30; l++) begin
            if (busy_a || done_a) extra++;
            @(negedge clk);
        end
        chk("rst_no_resume", 48'(extra), 48'(0));

        for (int k = 0; k < 1000 && !b_finished; k++) @(negedge clk);
        chk("auto_finished", 48'(b_finished), 48'(1));
        chk("sb_drained", 48'(exp_q.size()), 48'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : auto_proc
        int nd, prevn, early;
        logic [47:0] exp_b;
        b_finished = 1'b0;
        rst_b_n    = 1'b0;
        digits_b   = 24'hFEDCBA;
        exp_b      = model_hex(24'hFEDCBA, 6'h0, 6'h0);
        nd = 0; prevn = 0; early = 0;
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
        for (int n = 1; n <= 134; n++) begin
            @(negedge clk);
            if (done_b) begin
                if (nd == 0) chk("auto_first_done", 48'(n), 48'(50));
                else         chk("auto_period", 48'(n - prevn), 48'(32));
                chk("auto_hex", hex_b, exp_b);
                prevn = n;
                nd++;
            end
        end
        chk("auto_done_count", 48'(nd), 48'(3));
        chk("auto_busy_mid", 48'(busy_b), 48'(1));
        #2 rst_b_n = 1'b0;
        #1;
        chk("auto_rst_hex", hex_b, 48'hFFFF_FFFF_FFFF);
        chk("auto_rst_busy", 48'(busy_b), 48'(0));
        chk("auto_rst_addr", 48'(rom_addr_b), 48'(0));
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n < 32 && busy_b) early++;
            if (n < 50 && done_b) early++;
            if (n == 50) chk("auto_post_rst_done", 48'(done_b), 48'(1));
        end
        chk("auto_no_early_sweep", 48'(early), 48'(0));
        b_finished = 1'b1;
    end

endmodule
`default_nettype wire
